// File: rtl/rr_priority_encoder.sv
// N-way request picker with registered grant behind a valid/ready handshake; fixed or round-robin.
// Define RR_PRIORITY_ENCODER_MASK_EN to add the req_mask port (effective request = req & ~req_mask).
module rr_priority_encoder #(
    parameter int unsigned N           = 16,
    parameter int unsigned IDX_W       = $clog2(N),
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
`ifdef RR_PRIORITY_ENCODER_MASK_EN
    input  logic [N-1:0]     req_mask,
`endif
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic             any_req
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N-1:0]     eff_req;
    logic             accept;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] base;
    logic [2*N-1:0]   rot;
    logic [IDX_W-1:0] off;
    logic             wrap;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;

`ifdef RR_PRIORITY_ENCODER_MASK_EN
    assign eff_req = req & ~req_mask;
`else
    assign eff_req = req;
`endif

    assign any_req     = |eff_req;
    assign grant_valid = (state_q == StHold);
    assign accept      = grant_valid & grant_ready;
    assign next_ptr    = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

    // On accept the scan already starts after the outgoing winner, so it drops to lowest priority.
    assign base = (ROUND_ROBIN != 0) ? (accept ? next_ptr : ptr_q) : '0;

    always_comb begin
        rot = {eff_req, eff_req} >> base;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        // base + off stays below 2N; fold it back into 0..N-1 without a wider sum.
        wrap       = ({1'b0, off} >= ((IDX_W + 1)'(N) - {1'b0, base}));
        win_idx    = wrap ? (base + off - IDX_W'(N)) : (base + off);
        win_onehot = N'(1) << win_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q      <= StHold;
                        grant_idx    <= win_idx;
                        grant_onehot <= win_onehot;
                    end
                end
                StHold: begin
                    if (grant_ready) begin
                        ptr_q <= next_ptr;
                        if (any_req) begin
                            grant_idx    <= win_idx;
                            grant_onehot <= win_onehot;
                        end else begin
                            state_q      <= StIdle;
                            grant_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    grant_onehot <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model,
// covering a round-robin instance and a fixed-priority instance driven by the same stimulus.
module tb_rr_priority_encoder;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [N-1:0]  req;
`ifdef RR_PRIORITY_ENCODER_MASK_EN
    logic [N-1:0]  mask;
`endif

    logic          rr_valid, fp_valid;
    logic [IW-1:0] rr_idx, fp_idx;
    logic [N-1:0]  rr_oh, fp_oh;
    logic          rr_any, fp_any;

    int n_vec = 0;
    int n_err = 0;

    bit mv[2];
    int midx[2];
    int mptr[2];

    always #5 clk = ~clk;

    rr_priority_encoder #(.N(N), .IDX_W(IW), .ROUND_ROBIN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
`ifdef RR_PRIORITY_ENCODER_MASK_EN
        .req_mask     (mask),
`endif
        .grant_valid  (rr_valid),
        .grant_ready  (ready),
        .grant_idx    (rr_idx),
        .grant_onehot (rr_oh),
        .any_req      (rr_any)
    );

    rr_priority_encoder #(.N(N), .IDX_W(IW), .ROUND_ROBIN(0)) dut_fp (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
`ifdef RR_PRIORITY_ENCODER_MASK_EN
        .req_mask     (mask),
`endif
        .grant_valid  (fp_valid),
        .grant_ready  (ready),
        .grant_idx    (fp_idx),
        .grant_onehot (fp_oh),
        .any_req      (fp_any)
    );

    function automatic logic [N-1:0] eff();
`ifdef RR_PRIORITY_ENCODER_MASK_EN
        return req & ~mask;
`else
        return req;
`endif
    endfunction

    // First pending source met when walking upward from p and wrapping past N-1.
    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_edge();
        logic [N-1:0] e;
        e = eff();
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                mv[u] = 1'b0; midx[u] = 0; mptr[u] = 0;
            end else if (!mv[u]) begin
                if (e != '0) begin
                    mv[u]   = 1'b1;
                    midx[u] = pick(e, (u == 0) ? mptr[u] : 0);
                end
            end else if (ready) begin
                mptr[u] = (midx[u] == N - 1) ? 0 : midx[u] + 1;
                if (e != '0) midx[u] = pick(e, (u == 0) ? mptr[u] : 0);
                else         mv[u] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] oh0, oh1;
        oh0 = mv[0] ? (64'd1 << midx[0]) : 64'd0;
        oh1 = mv[1] ? (64'd1 << midx[1]) : 64'd0;
        chk("rr_valid",  64'(rr_valid), 64'(mv[0]));
        chk("rr_idx",    64'(rr_idx),   64'(midx[0]));
        chk("rr_onehot", 64'(rr_oh),    oh0);
        chk("rr_any",    64'(rr_any),   64'(eff() != '0));
        chk("fp_valid",  64'(fp_valid), 64'(mv[1]));
        chk("fp_idx",    64'(fp_idx),   64'(midx[1]));
        chk("fp_onehot", 64'(fp_oh),    oh1);
        chk("fp_any",    64'(fp_any),   64'(eff() != '0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int rot_seq[8] = '{0, 5, 10, 15, 0, 5, 10, 15};

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0;
`ifdef RR_PRIORITY_ENCODER_MASK_EN
        mask = '0;
`endif
        // Reset, then an empty request bus.
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("empty_valid", 64'(rr_valid), 64'd0);
            chk("empty_idx",   64'(rr_idx),   64'd0);
            chk("empty_oh",    64'(rr_oh),    64'd0);
        end

        // Round-robin rotation with full throughput.
        req = 16'h8421; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rot_idx",   64'(rr_idx),   64'(rot_seq[i]));
            chk("rot_valid", 64'(rr_valid), 64'd1);
        end
        req = '0;
        cycle();
        chk("drain_valid", 64'(rr_valid), 64'd0);

        // Backpressure: grant is sticky after its request drops.
        ready = 1'b0; req = 16'h0010;
        cycle();
        chk("bp_idx", 64'(rr_idx), 64'd4);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_idx",   64'(rr_idx),   64'd4);
            chk("bp_hold_valid", 64'(rr_valid), 64'd1);
        end
        ready = 1'b1;
        cycle();
        chk("bp_idle", 64'(rr_valid), 64'd0);

        // Wrap through ptr=15 and a lone requester re-granted.
        ready = 1'b0; req = 16'h4000;
        cycle();
        chk("wrap_pre_idx", 64'(rr_idx), 64'd14);
        req = 16'h0001; ready = 1'b1;
        cycle();
        chk("wrap_idx", 64'(rr_idx), 64'd0);
        cycle();
        chk("regrant_idx",   64'(rr_idx),   64'd0);
        chk("regrant_valid", 64'(rr_valid), 64'd1);

        // Fixed priority: index 8 beats 9 on every accept.
        req = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fixed_idx", 64'(fp_idx), 64'd8);
        end

`ifdef RR_PRIORITY_ENCODER_MASK_EN
        // Masked line 0 never wins; reset mid-grant drops the grant.
        rst = 1'b1; req = '0; ready = 1'b0;
        cycle();
        rst = 1'b0; mask = 16'h0001; req = 16'h0003;
        cycle();
        chk("mask_idx", 64'(rr_idx), 64'd1);
        rst = 1'b1;
        cycle();
        chk("mask_rst_valid", 64'(rr_valid), 64'd0);
        rst = 1'b0;
        cycle();
        chk("mask_post_idx", 64'(rr_idx), 64'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            req   = N'($urandom) & N'($urandom);
            ready = ($urandom_range(0, 2) != 0);
`ifdef RR_PRIORITY_ENCODER_MASK_EN
            mask  = N'($urandom) & N'($urandom) & N'($urandom);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
